// File: rtl/leaf_arb_pkg.sv
// Shared definitions for the leaf output stream arbiter.
// Holds the FSM state encoding, a constant-capable clog2 helper used to size
// the beat counter, and the default burst length.
package leaf_arb_pkg;

  // Two-state arbiter: IDLE spends one cycle choosing a source, GRANT streams it
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEFAULT_MAX_BURST = 16;

  // Smallest width able to index 'value' distinct codes (clog2(1) = 0)
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/leaf_out_stream_arbiter_rr_pick.sv
// Combinational cyclic priority picker.
// Starting just after the previously granted index, scans the request vector
// cyclically and returns the first requester found.
// Ports:
//   req_i  - one request bit per source
//   last_i - index granted most recently (lowest priority this round)
//   pick_o - chosen source index (0 when nothing requests)
//   any_o  - high when at least one source requests
module rr_pick
  import leaf_arb_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int SRC_BITS = 2
) (
  input  logic [NUM_SRC-1:0]  req_i,
  input  logic [SRC_BITS-1:0] last_i,
  output logic [SRC_BITS-1:0] pick_o,
  output logic                any_o
);

  // Walk offsets 1..NUM_SRC from last_i; offset NUM_SRC lands back on last_i,
  // so a lone requester that was just served can still win.
  always_comb begin
    logic [SRC_BITS-1:0] idx;
    idx    = '0;
    pick_o = '0;
    any_o  = 1'b0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = SRC_BITS'((int'(last_i) + off) % NUM_SRC);
      if (!any_o && req_i[idx]) begin
        pick_o = idx;
        any_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_stream_arbiter.sv
// Shares one leaf user->interface output stream among NUM_SRC user streams.
// Sources are granted round-robin in bursts of up to MAX_BURST beats; a single
// output register gives a fixed one-cycle latency, and out_src_o tags each beat
// with the source it came from.
// Ports:
//   clk_i, reset_i  - clock, asynchronous active-high reset
//   en_i            - allows new grants (ap_start_user); a running burst finishes
//   in_data_i       - packed source payloads, src i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//   in_vld_i        - per-source valid
//   in_ack_o        - per-source ready, at most one bit set
//   out_data_o      - beat payload towards din_leaf_user2interface
//   out_vld_o       - towards vld_user2interface
//   out_ack_i       - from ack_interface2user
//   out_src_o       - source index of the beat in out_data_o
//   busy_o          - high while a grant is open or a beat is still held
module leaf_out_stream_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = DEFAULT_MAX_BURST,
  parameter int SRC_BITS     = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            en_i,
  input  logic [NUM_SRC*PAYLOAD_BITS-1:0] in_data_i,
  input  logic [NUM_SRC-1:0]              in_vld_i,
  output logic [NUM_SRC-1:0]              in_ack_o,
  output logic [PAYLOAD_BITS-1:0]         out_data_o,
  output logic                            out_vld_o,
  input  logic                            out_ack_i,
  output logic [SRC_BITS-1:0]             out_src_o,
  output logic                            busy_o
);

  // The counter only has to reach MAX_BURST, where the FSM always leaves GRANT
  localparam int                  CNT_BITS   = clog2(MAX_BURST + 1);
  localparam logic [CNT_BITS-1:0] BURST_LAST = CNT_BITS'(MAX_BURST);

  arb_state_e                state_q, state_d;
  logic [SRC_BITS-1:0]       gnt_q, gnt_d;
  logic [SRC_BITS-1:0]       rrLast_q, rrLast_d;
  logic [CNT_BITS-1:0]       beatCnt_q, beatCnt_d;
  logic [PAYLOAD_BITS-1:0]   outData_q, outData_d;
  logic [SRC_BITS-1:0]       outSrc_q, outSrc_d;
  logic                      outVld_q, outVld_d;

  logic                      inReady;
  logic                      inXfer;
  logic                      outXfer;
  logic [SRC_BITS-1:0]       pickIdx;
  logic                      pickAny;

  rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .SRC_BITS (SRC_BITS)
  ) u_rr_pick (
    .req_i  (in_vld_i),
    .last_i (rrLast_q),
    .pick_o (pickIdx),
    .any_o  (pickAny)
  );

  // Handshake: the output register can take a beat when empty or draining this
  // cycle; only the granted source ever sees that ready.
  always_comb begin
    inReady  = !outVld_q || out_ack_i;
    in_ack_o = '0;
    if (state_q == GRANT) begin
      in_ack_o[gnt_q] = inReady;
    end
    inXfer  = (state_q == GRANT) && inReady && in_vld_i[gnt_q];
    outXfer = outVld_q && out_ack_i;
  end

  // Grant FSM: IDLE arbitrates for one cycle, GRANT streams the chosen source
  // until the burst is full or the source runs dry while it could have sent.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rrLast_d  = rrLast_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      IDLE: begin
        if (en_i && pickAny) begin
          gnt_d     = pickIdx;
          rrLast_d  = pickIdx;
          beatCnt_d = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (inXfer) begin
          beatCnt_d = beatCnt_q + CNT_BITS'(1);
          if (beatCnt_d == BURST_LAST) begin
            state_d = IDLE;
          end
        end else if (inReady) begin
          // Ready was offered but in_vld was low: give up the grant
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: reload on every accepted input beat (even while draining, so
  // no bubble), otherwise empty once the held beat is taken.
  always_comb begin
    outData_d = outData_q;
    outSrc_d  = outSrc_q;
    outVld_d  = outVld_q;
    if (inXfer) begin
      outData_d = in_data_i[int'(gnt_q)*PAYLOAD_BITS +: PAYLOAD_BITS];
      outSrc_d  = gnt_q;
      outVld_d  = 1'b1;
    end else if (outXfer) begin
      outVld_d = 1'b0;
    end
  end

  // State and datapath registers; rrLast starts at the top index so source 0
  // wins the first arbitration after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rrLast_q  <= SRC_BITS'(NUM_SRC - 1);
      beatCnt_q <= '0;
      outData_q <= '0;
      outSrc_q  <= '0;
      outVld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rrLast_q  <= rrLast_d;
      beatCnt_q <= beatCnt_d;
      outData_q <= outData_d;
      outSrc_q  <= outSrc_d;
      outVld_q  <= outVld_d;
    end
  end

  assign out_data_o = outData_q;
  assign out_src_o  = outSrc_q;
  assign out_vld_o  = outVld_q;
  assign busy_o     = (state_q == GRANT) || outVld_q;

endmodule
